// File: rtl/dmem_mmio_responder_if.sv
// Memory-stage data bus and transmit-stream signals shared between the core/sink side
// and the data-memory/MMIO responder.
interface dmem_mmio_responder_if;
    logic        MemWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        drop_pulse;

    modport master (
        output MemWriteM, AddrM, WriteDataM, tx_ready,
        input  ReadDataM, tx_data, tx_valid, drop_pulse
    );

    modport slave (
        input  MemWriteM, AddrM, WriteDataM, tx_ready,
        output ReadDataM, tx_data, tx_valid, drop_pulse
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Word-addressed data RAM plus an MMIO window (TX FIFO, status, cycle and drop counters)
// answering the core's M-stage accesses; loads are combinational, stores commit at the edge.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_mmio_responder_if.slave bus
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] OFF_TX_DATA = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_CYCLE   = 2'd2;
    localparam logic [1:0] OFF_DROP    = 2'd3;

    logic        ram_hit;
    logic        mmio_hit;
    logic [1:0]  offset;

    logic [31:0] mem_q [RAM_WORDS];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [31:0]   cyc_q,    cyc_d;
    logic [31:0]   drops_q,  drops_d;
    logic          drop_pulse_q, drop_pulse_d;

    logic [FIFO_DEPTH-1:0][31:0] fifo_word;

    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic [31:0] head_word;
    logic [31:0] read_data;

    assign ram_hit  = bus.AddrM < RAM_BYTES;
    assign mmio_hit = bus.AddrM[31:4] == MMIO_BASE[31:4];
    assign offset   = bus.AddrM[3:2];

    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == DEPTH_C;
    assign head_word  = fifo_word[rd_ptr_q];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign pop      = ~fifo_empty & bus.tx_ready;
    assign push_req = bus.MemWriteM & mmio_hit & (offset == OFF_TX_DATA);
    assign push_ok  = push_req & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (bus.MemWriteM && ram_hit) begin
            mem_q[bus.AddrM[AW+1:2]] <= bus.WriteDataM;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [31:0] entry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push_ok && (wr_ptr_q == PW'(gi))) begin
                    entry_q <= bus.WriteDataM;
                end
            end

            assign fifo_word[gi] = entry_q;
        end
    endgenerate

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        drops_d      = drops_q;
        drop_pulse_d = push_req & ~push_ok;
        cyc_d        = cyc_q + 32'd1;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok && (drops_q != 32'hFFFF_FFFF)) begin
            drops_d = drops_q + 32'd1;
        end

        if (bus.MemWriteM && mmio_hit && (offset == OFF_CYCLE)) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            cyc_q        <= '0;
            drops_q      <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            cyc_q        <= cyc_d;
            drops_q      <= drops_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = mem_q[bus.AddrM[AW+1:2]];
        end else if (mmio_hit) begin
            unique case (offset)
                OFF_TX_DATA: read_data = fifo_empty ? 32'd0 : head_word;
                OFF_STATUS:  read_data = 32'({count_q, fifo_full, fifo_empty});
                OFF_CYCLE:   read_data = cyc_q;
                OFF_DROP:    read_data = drops_q;
                default:     read_data = '0;
            endcase
        end
    end

    assign bus.ReadDataM  = read_data;
    assign bus.tx_data    = head_word;
    assign bus.tx_valid   = ~fifo_empty;
    assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a queue/array reference model checked against
// the DUT every cycle, plus hand-computed literal expectations at key points.
module tb_dmem_mmio_responder;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(DEPTH),
        .MMIO_BASE (BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_q [$];
    logic [31:0] m_ram [int];
    logic [31:0] m_cyc;
    logic [31:0] m_drops;
    logic        m_dp;
    bit          m_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        int n;
        n = m_q.size();
        if (addr < 32'd256) return m_ram[int'(addr >> 2)];
        if (addr[31:4] != BASE[31:4]) return 32'd0;
        case (addr[3:2])
            2'd0:    return (n == 0) ? 32'd0 : m_q[0];
            2'd1:    return 32'(n * 4 + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
            2'd2:    return m_cyc;
            default: return m_drops;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit mmio, pop, preq, acc;
        mmio = bus.AddrM[31:4] == BASE[31:4];
        if (bus.MemWriteM && bus.AddrM < 32'd256) m_ram[int'(bus.AddrM >> 2)] = bus.WriteDataM;
        if (rst) begin
            m_q.delete();
            m_cyc   = 0;
            m_drops = 0;
            m_dp    = 0;
            m_ok    = 1;
        end else begin
            pop  = (m_q.size() != 0) && bus.tx_ready;
            preq = bus.MemWriteM && mmio && (bus.AddrM[3:2] == 2'd0);
            acc  = preq && ((m_q.size() < DEPTH) || pop);
            m_dp = preq && !acc;
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back(bus.WriteDataM);
            if (m_dp && m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            if (bus.MemWriteM && mmio && bus.AddrM[3:2] == 2'd2) m_cyc = 0;
            else m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            if (!(bus.AddrM < 32'd256 && !m_ram.exists(int'(bus.AddrM >> 2))))
                check("cmp_rdata", bus.ReadDataM, exp_read(bus.AddrM));
            check("cmp_tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("cmp_tx_data", bus.tx_data, m_q[0]);
            check("cmp_drop_pulse", 32'(bus.drop_pulse), 32'(m_dp));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWriteM  = 1'b1;
        bus.AddrM      = addr;
        bus.WriteDataM = data;
        $display("txn store addr=%08h data=%08h tx_ready=%0d rst=%0d", addr, data, bus.tx_ready, rst);
        step();
        bus.MemWriteM = 1'b0;
    endtask

    task automatic load_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.MemWriteM = 1'b0;
        bus.AddrM     = addr;
        #1;
        $display("txn load  addr=%08h data=%08h", addr, bus.ReadDataM);
        check(name, bus.ReadDataM, exp);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.MemWriteM = 1'b0;
        step();
        step();
        rst = 1'b0;
        $display("txn reset");
    endtask

    initial begin
        rst            = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.AddrM      = BASE + 32'h8;
        bus.WriteDataM = '0;
        bus.tx_ready   = 1'b0;

        // Reset and RAM/unmapped decode
        do_reset();
        check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("reset_drop_pulse", 32'(bus.drop_pulse), 32'd0);
        load_check("reset_status", BASE + 32'h4, 32'h0000_0001);
        store(32'h10, 32'hDEADBEEF);
        load_check("ram_readback", 32'h10, 32'hDEADBEEF);
        check("model_ram", m_ram[4], 32'hDEADBEEF);
        store(32'h1000_0000, 32'h5555_AAAA);
        load_check("unmapped_read", 32'h1000_0000, 32'd0);

        // Fill FIFO, then overflow
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) store(BASE, 32'(i));
        load_check("status_full", BASE + 32'h4, 32'h0000_0022);
        check("model_count", 32'(m_q.size()), 32'd8);
        store(BASE, 32'd9);
        check("drop_pulse_hi", 32'(bus.drop_pulse), 32'd1);
        load_check("drop_count", BASE + 32'hC, 32'd1);
        step();
        check("drop_pulse_lo", 32'(bus.drop_pulse), 32'd0);
        load_check("head_after_drop", BASE, 32'd1);

        // Push into full FIFO while head leaves
        bus.tx_ready = 1'b1;
        store(BASE, 32'd9);
        bus.tx_ready = 1'b0;
        load_check("status_full_again", BASE + 32'h4, 32'h0000_0022);
        load_check("drops_unchanged", BASE + 32'hC, 32'd1);
        load_check("head_is_2", BASE, 32'd2);
        bus.tx_ready = 1'b1;
        bus.AddrM    = BASE + 32'h4;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", 32'(bus.tx_valid), 32'd1);
            check("drain_data", bus.tx_data, 32'(2 + k));
            $display("txn pop data=%08h", bus.tx_data);
            step();
        end
        check("drained_valid", 32'(bus.tx_valid), 32'd0);
        load_check("drained_status", BASE + 32'h4, 32'h0000_0001);

        // Single push with sink always ready
        store(BASE, 32'd5);
        check("single_valid", 32'(bus.tx_valid), 32'd1);
        check("single_data", bus.tx_data, 32'd5);
        step();
        check("single_gone", 32'(bus.tx_valid), 32'd0);
        load_check("single_status", BASE + 32'h4, 32'h0000_0001);

        // Cycle counter
        bus.tx_ready = 1'b0;
        do_reset();
        bus.AddrM = BASE + 32'h8;
        repeat (10) step();
        load_check("cycle_10", BASE + 32'h8, 32'd10);
        store(BASE + 32'h8, 32'h1234_5678);
        load_check("cycle_clear", BASE + 32'h8, 32'd0);
        step();
        load_check("cycle_one", BASE + 32'h8, 32'd1);

        // Mid-stream reset with a coincident push
        store(BASE, 32'hA);
        store(BASE, 32'hB);
        store(BASE, 32'hC);
        load_check("status_three", BASE + 32'h4, 32'h0000_000C);
        rst            = 1'b1;
        bus.MemWriteM  = 1'b1;
        bus.AddrM      = BASE;
        bus.WriteDataM = 32'hD;
        step();
        rst           = 1'b0;
        bus.MemWriteM = 1'b0;
        $display("txn reset with push");
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        load_check("rst_status", BASE + 32'h4, 32'h0000_0001);
        load_check("rst_drops", BASE + 32'hC, 32'd0);
        load_check("rst_cycle", BASE + 32'h8, 32'd0);
        load_check("ram_survives_rst", 32'h10, 32'hDEADBEEF);
        check("model_empty", 32'(m_q.size()), 32'd0);

        bus.AddrM = BASE + 32'h8;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Memory-stage responder for the pipelined core. It answers the core's data accesses (address, write data and write enable presented in M) with word-addressed data RAM plus a small MMIO window. The MMIO window provides a transmit FIFO drained by an external valid/ready sink, a status register, a free-running cycle counter and a drop counter. Reads are combinational, so the core registers read data into W in the same cycle; writes commit at the clock edge.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; power of two.
FIFO_DEPTH, 8, transmit FIFO entries; power of two, at least 2.
MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window; 16-byte aligned.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
MemWriteM  input  1  core store enable (already condition-qualified)
AddrM  input  32  byte address (core ALU result in M); bits [1:0] ignored
WriteDataM  input  32  store data
ReadDataM  output  32  load data, combinational from AddrM and current state
tx_data  output  32  FIFO head word
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  sink accepts head when tx_valid & tx_ready
drop_pulse  output  1  registered one-cycle pulse: a push was rejected last cycle

Behaviour:
- Decode, word index w = AddrM[31:2]:
  - RAM hit when AddrM < RAM_WORDS*4.
  - MMIO hit when AddrM[31:4] == MMIO_BASE[31:4].
  - Any other address: reads return 0, writes are ignored.
- RAM:
  - Read: ReadDataM = mem[w] combinationally.
  - Write: mem[w] <= WriteDataM when MemWriteM.
  - RAM contents are not affected by rst.
- MMIO offsets (AddrM[3:2]):
  - 0 TX_DATA. Write pushes WriteDataM. Read returns the head word, or 0 when empty; reading does not pop.
  - 1 STATUS, read-only. Returns {zero pad, count[CW-1:0], full, empty} with count in bits [CW+1:2], full in bit 1, empty in bit 0, where CW = log2(FIFO_DEPTH)+1. Writes are ignored.
  - 2 CYCLE. Read returns cyc. Any write sets cyc <= 0 at that edge; otherwise cyc increments every cycle and wraps 2^32-1 -> 0.
  - 3 DROP. Read returns drops. Writes are ignored. drops saturates at 32'hFFFF_FFFF.
- FIFO is circular with rd_ptr, wr_ptr and count:
  - pop = tx_valid & tx_ready.
  - push_req = MemWriteM & MMIO hit & offset 0.
  - push accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and pop is asserted in the same cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Pop when empty is impossible because tx_valid = 0.
  - Rejected push: drops increments and drop_pulse = 1 in the next cycle; FIFO state is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data/tx_valid derive combinationally from rd_ptr and count. tx_valid must not depend on tx_ready.
  - tx_data is stable while tx_valid & ~tx_ready.
- Reset, synchronous:
  - count = 0, rd_ptr = 0, wr_ptr = 0, cyc = 0, drops = 0, drop_pulse = 0.
  - Resulting outputs: tx_valid = 0, tx_data = 0 (entry storage is cleared), ReadDataM follows decode with the reset state.
- rst asserted mid-stream discards all queued entries in that cycle. A push or pop coincident with rst has no effect.
- Latency:
  - Store to RAM is visible to a load in the following cycle.
  - Push is visible on tx_valid in the next cycle.
  - STATUS reflects pushes and pops from the previous edge.

Test Plan:
1. Reset, then store 32'hDEADBEEF to 0x10 and load 0x10 next cycle -> ReadDataM = 32'hDEADBEEF. Load 0x1000_0000 -> 0.
2. tx_ready = 0; push 8 words 1..8 -> STATUS = {count=8, full=1, empty=0}. 9th push -> drop_pulse high one cycle, DROP = 1, head still 1.
3. FIFO full with tx_ready = 1 and a push of 9 in the same cycle -> push accepted, count stays 8, drops unchanged. Drained order is 2..9.
4. Empty FIFO, push 5 and hold tx_ready = 1 -> tx_valid high exactly one cycle with tx_data = 5, then STATUS empty = 1.
5. After reset, read CYCLE at cycle 10 -> 10. Write CYCLE -> reads 0 at the next cycle, then 1.
6. Push 3 entries, assert rst one cycle -> tx_valid = 0, count = 0, DROP = 0, and RAM word written in test 1 still reads 32'hDEADBEEF.
